// File: rtl/timer_unit.sv
// Memory-mapped countdown timer responding on the core data bus.
// Reads take one wait state (mem_wait in the request cycle, data the next); writes commit with no wait.
// One transfer per en assertion; en held longer parks the responder in HOLD until en drops.
module timer_unit #(
   parameter logic [15:0] BASE_ADDR = 16'h3F00,
   parameter int          PRESC_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] addr,
   input  logic        write_enable,
   input  logic        byte_enable,
   input  logic        byte_select,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        serviced_read,
   output logic        mem_wait,
   output logic        irq
);

   typedef enum logic [1:0] {IDLE, RD_RESP, HOLD} state_t;

   state_t state;
   state_t state_nxt;

   // programmable state
   logic               run;
   logic               auto_reload;
   logic               irq_en;
   logic [3:0]         presc_sel;
   logic [15:0]        count;
   logic [15:0]        reload;
   logic               expired;
   logic [PRESC_W-1:0] prescaler;

   // decode and datapath helpers
   logic               hit;
   logic               rd_req;
   logic               wr_req;
   logic [1:0]         offs;
   logic [15:0]        ctrl_word;
   logic [15:0]        sel_word;
   logic [15:0]        rd_word;
   logic [15:0]        wr_word;
   logic               wr_ctrl;
   logic               wr_count;
   logic               wr_reload;
   logic               w1c_status;
   logic [PRESC_W-1:0] tick_mask;
   logic               tick;
   logic               expire_evt;

   assign hit  = en & (addr[15:2] == BASE_ADDR[15:2]);
   assign offs = addr[1:0];

   // Bus FSM next state; a request is only accepted from IDLE so a long en yields one transfer
   always_comb begin
      state_nxt = state;
      rd_req    = 1'b0;
      wr_req    = 1'b0;
      case (state)
         IDLE: begin
            if (hit) begin
               if (write_enable) begin
                  wr_req    = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  rd_req    = 1'b1;
                  state_nxt = RD_RESP;
               end
            end
         end
         RD_RESP: state_nxt = en ? HOLD : IDLE;
         HOLD:    if (!en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The stall is combinational so the core holds in the request cycle; suppressed under reset
   assign mem_wait      = rd_req & ~rst;
   assign serviced_read = (state == RD_RESP);

   // Register mux shared by the read path and the byte-write merge
   always_comb begin
      ctrl_word = {8'h00, presc_sel, 1'b0, irq_en, auto_reload, run};
      sel_word  = 16'h0000;
      case (offs)
         2'd0: sel_word = ctrl_word;
         2'd1: sel_word = count;
         2'd2: sel_word = reload;
         2'd3: sel_word = {15'h0000, expired};
         default: sel_word = 16'h0000;
      endcase
      if (byte_enable) begin
         rd_word = byte_select ? {8'h00, sel_word[15:8]} : {8'h00, sel_word[7:0]};
         wr_word = byte_select ? {data_in[15:8], sel_word[7:0]} : {sel_word[15:8], data_in[7:0]};
      end else begin
         rd_word = sel_word;
         wr_word = data_in;
      end
   end

   assign wr_ctrl    = wr_req & (offs == 2'd0);
   assign wr_count   = wr_req & (offs == 2'd1);
   assign wr_reload  = wr_req & (offs == 2'd2);
   assign w1c_status = wr_req & (offs == 2'd3) & (~byte_enable | ~byte_select) & data_in[0];

   // Tick mask covers prescaler[p:0]; selections beyond the counter width saturate to all ones
   always_comb begin
      tick_mask = '0;
      for (int i = 0; i < PRESC_W; i++) begin
         tick_mask[i] = (i <= int'(presc_sel));
      end
   end

   assign tick       = run & ((prescaler & tick_mask) == tick_mask);
   assign expire_evt = tick & (count == 16'h0000);

   // Bus FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Read data is captured in the wait cycle and held through the response
   always_ff @(posedge clk) begin
      if (rst)         data_out <= 16'h0000;
      else if (rd_req) data_out <= rd_word;
   end

   // Prescaler free-runs while the timer is enabled and restarts from zero when stopped
   always_ff @(posedge clk) begin
      if (rst || !run) prescaler <= '0;
      else             prescaler <= prescaler + 1'b1;
   end

   // Register file and countdown; a bus write to COUNT/CTRL overrides that cycle's tick update
   always_ff @(posedge clk) begin
      if (rst) begin
         run         <= 1'b0;
         auto_reload <= 1'b0;
         irq_en      <= 1'b0;
         presc_sel   <= 4'h0;
         count       <= 16'h0000;
         reload      <= 16'h0000;
         expired     <= 1'b0;
      end else begin
         if (tick && !(wr_ctrl || wr_count)) begin
            if (count != 16'h0000) count <= count - 16'd1;
            else if (auto_reload)  count <= reload;
            else                   run   <= 1'b0;
         end
         if (wr_ctrl) begin
            run         <= wr_word[0];
            auto_reload <= wr_word[1];
            irq_en      <= wr_word[2];
            presc_sel   <= wr_word[7:4];
         end
         if (wr_count)  count  <= wr_word;
         if (wr_reload) reload <= wr_word;
         // a new expiry outranks a simultaneous clear
         if (expire_evt)      expired <= 1'b1;
         else if (w1c_status) expired <= 1'b0;
      end
   end

   // Interrupt level, registered from the sticky flag and its enable
   always_ff @(posedge clk) begin
      if (rst) irq <= 1'b0;
      else     irq <= expired & irq_en;
   end

endmodule
